// File: rtl/spike_rate_counter_pkg.sv
// Shared widths and FSM encoding for the spike-rate accumulator.
// The localparams supply the default channel count, index width and rate width.
package spike_rate_counter_pkg;

  localparam int CH_NUM_DEF   = 8;
  localparam int CH_BIT_DEF   = 3;
  localparam int RATE_BIT_DEF = 8;

  typedef enum logic [2:0] {
    ST_INIT   = 3'd0,
    ST_ACC    = 3'd1,
    ST_DRAIN  = 3'd2,
    ST_SW_RD  = 3'd3,
    ST_SW_OUT = 3'd4
  } state_e;

endpackage

// File: rtl/spike_rate_counter.sv
// Per-channel spike counter: read-modify-write into an external RAM, plus a
// frame-boundary sweep that emits {cur, prev} per channel and rolls cur into prev.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_INIT   | clear RAM words 0..CH_NUM-1, one per cycle
// ST_ACC    | accept events; stage R reads, stage M writes the incremented word
// ST_DRAIN  | one cycle so the last stage-M write lands before the sweep reads
// ST_SW_RD  | issue RAM read for the current sweep channel
// ST_SW_OUT | present the record; on handshake write {cur, 0} and advance
module spike_rate_counter
  import spike_rate_counter_pkg::*;
#(
  parameter int CH_NUM   = CH_NUM_DEF,
  parameter int CH_BIT   = CH_BIT_DEF,
  parameter int RATE_BIT = RATE_BIT_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [CH_BIT-1:0]     in_ch,
  output logic                  in_ready,
  input  logic                  frame_end,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CH_BIT-1:0]     out_ch,
  output logic [RATE_BIT-1:0]   out_cur,
  output logic [RATE_BIT-1:0]   out_prev,
  output logic                  sweep_busy,
  output logic                  overrun,
  output logic [CH_BIT-1:0]     ram_raddr,
  input  logic [2*RATE_BIT-1:0] ram_dout,
  output logic [CH_BIT-1:0]     ram_waddr,
  output logic [2*RATE_BIT-1:0] ram_din,
  output logic                  ram_we
);

  localparam int                WORD_BIT = 2 * RATE_BIT;
  localparam int                CUR_LSB  = 0;
  localparam int                PREV_LSB = RATE_BIT;
  localparam logic [CH_BIT-1:0] CH_LAST  = CH_BIT'(CH_NUM - 1);
  localparam logic [RATE_BIT-1:0] RATE_MAX = {RATE_BIT{1'b1}};

  state_e              state_q, state_d;
  logic [CH_BIT-1:0]   ch_q, ch_d;
  logic                m_valid_q, m_valid_d;
  logic [CH_BIT-1:0]   m_ch_q, m_ch_d;
  logic                wr_valid_q, wr_valid_d;
  logic [CH_BIT-1:0]   wr_ch_q, wr_ch_d;
  logic [WORD_BIT-1:0] wr_word_q, wr_word_d;
  logic                out_valid_q, out_valid_d;
  logic                hold_valid_q, hold_valid_d;
  logic [WORD_BIT-1:0] hold_word_q, hold_word_d;
  logic                overrun_q, overrun_d;

  logic                accept;
  logic                handshake;
  logic [WORD_BIT-1:0] m_base;
  logic [RATE_BIT-1:0] m_base_cur;
  logic [RATE_BIT-1:0] m_new_cur;
  logic [WORD_BIT-1:0] m_word;
  logic [WORD_BIT-1:0] sw_word;

  assign in_ready   = (state_q == ST_ACC);
  assign sweep_busy = (state_q != ST_ACC);
  assign overrun    = overrun_q;
  assign accept     = in_valid && in_ready;
  assign handshake  = out_valid_q && out_ready;

  // The RAM returns the old word when read and written on the same edge, so
  // a same-channel event right behind another takes the word just written.
  assign m_base     = (wr_valid_q && (wr_ch_q == m_ch_q)) ? wr_word_q : ram_dout;
  assign m_base_cur = m_base[CUR_LSB +: RATE_BIT];
  assign m_new_cur  = (m_base_cur == RATE_MAX) ? RATE_MAX : m_base_cur + 1'b1;
  assign m_word     = {m_base[PREV_LSB +: RATE_BIT], m_new_cur};

  // ram_dout only carries the record for the first SW_OUT cycle; a stall
  // keeps the captured copy instead.
  assign sw_word = hold_valid_q ? hold_word_q : ram_dout;

  assign out_valid = out_valid_q;
  assign out_ch    = out_valid_q ? ch_q : '0;
  assign out_cur   = out_valid_q ? sw_word[CUR_LSB +: RATE_BIT] : '0;
  assign out_prev  = out_valid_q ? sw_word[PREV_LSB +: RATE_BIT] : '0;

  always_comb begin
    state_d      = state_q;
    ch_d         = ch_q;
    m_valid_d    = 1'b0;
    m_ch_d       = m_ch_q;
    wr_valid_d   = 1'b0;
    wr_ch_d      = wr_ch_q;
    wr_word_d    = wr_word_q;
    out_valid_d  = out_valid_q;
    hold_valid_d = 1'b0;
    hold_word_d  = hold_word_q;
    overrun_d    = overrun_q | (frame_end && (state_q != ST_ACC));
    ram_raddr    = '0;
    ram_waddr    = '0;
    ram_din      = '0;
    ram_we       = 1'b0;

    if (m_valid_q) begin
      ram_we     = 1'b1;
      ram_waddr  = m_ch_q;
      ram_din    = m_word;
      wr_valid_d = 1'b1;
      wr_ch_d    = m_ch_q;
      wr_word_d  = m_word;
    end

    case (state_q)
      ST_INIT: begin
        ram_we    = 1'b1;
        ram_waddr = ch_q;
        ram_din   = '0;
        if (ch_q == CH_LAST) begin
          ch_d    = '0;
          state_d = ST_ACC;
        end else begin
          ch_d = ch_q + 1'b1;
        end
      end
      ST_ACC: begin
        if (accept) begin
          ram_raddr = in_ch;
          m_valid_d = 1'b1;
          m_ch_d    = in_ch;
        end
        if (frame_end) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        ch_d    = '0;
        state_d = ST_SW_RD;
      end
      ST_SW_RD: begin
        ram_raddr   = ch_q;
        out_valid_d = 1'b1;
        state_d     = ST_SW_OUT;
      end
      ST_SW_OUT: begin
        if (handshake) begin
          ram_we      = 1'b1;
          ram_waddr   = ch_q;
          ram_din     = {sw_word[CUR_LSB +: RATE_BIT], {RATE_BIT{1'b0}}};
          out_valid_d = 1'b0;
          if (ch_q == CH_LAST) begin
            ch_d    = '0;
            state_d = ST_ACC;
          end else begin
            ch_d    = ch_q + 1'b1;
            state_d = ST_SW_RD;
          end
        end else begin
          hold_valid_d = 1'b1;
          hold_word_d  = sw_word;
        end
      end
      default: begin
        state_d = ST_INIT;
        ch_d    = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_INIT;
      ch_q         <= '0;
      m_valid_q    <= 1'b0;
      m_ch_q       <= '0;
      wr_valid_q   <= 1'b0;
      wr_ch_q      <= '0;
      wr_word_q    <= '0;
      out_valid_q  <= 1'b0;
      hold_valid_q <= 1'b0;
      hold_word_q  <= '0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      ch_q         <= ch_d;
      m_valid_q    <= m_valid_d;
      m_ch_q       <= m_ch_d;
      wr_valid_q   <= wr_valid_d;
      wr_ch_q      <= wr_ch_d;
      wr_word_q    <= wr_word_d;
      out_valid_q  <= out_valid_d;
      hold_valid_q <= hold_valid_d;
      hold_word_q  <= hold_word_d;
      overrun_q    <= overrun_d;
    end
  end

endmodule

// File: tb/tb_spike_rate_counter.sv
// Scoreboard bench for spike_rate_counter with a behavioural RAM that returns
// old data on a same-edge read/write, so the forwarding path is exercised.
module tb_spike_rate_counter;

  localparam int CH_NUM   = 8;
  localparam int CH_BIT   = 3;
  localparam int RATE_BIT = 4;
  localparam int W        = 2 * RATE_BIT;
  localparam int RMAX     = 15;

  logic                clk = 1'b0;
  logic                rst;
  logic                in_valid;
  logic [CH_BIT-1:0]   in_ch;
  logic                in_ready;
  logic                frame_end;
  logic                out_valid;
  logic                out_ready;
  logic [CH_BIT-1:0]   out_ch;
  logic [RATE_BIT-1:0] out_cur;
  logic [RATE_BIT-1:0] out_prev;
  logic                sweep_busy;
  logic                overrun;
  logic [CH_BIT-1:0]   ram_raddr;
  logic [W-1:0]        ram_dout;
  logic [CH_BIT-1:0]   ram_waddr;
  logic [W-1:0]        ram_din;
  logic                ram_we;
  logic                fill_en;

  logic [W-1:0] mem [CH_NUM];

  always #5 clk = ~clk;

  spike_rate_counter #(.CH_NUM(CH_NUM), .CH_BIT(CH_BIT), .RATE_BIT(RATE_BIT)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ch(in_ch), .in_ready(in_ready),
    .frame_end(frame_end),
    .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch),
    .out_cur(out_cur), .out_prev(out_prev),
    .sweep_busy(sweep_busy), .overrun(overrun),
    .ram_raddr(ram_raddr), .ram_dout(ram_dout),
    .ram_waddr(ram_waddr), .ram_din(ram_din), .ram_we(ram_we)
  );

  always @(posedge clk) begin
    if (fill_en) begin
      for (int i = 0; i < CH_NUM; i++) mem[i] <= 8'hA5;
    end else if (ram_we) begin
      mem[ram_waddr] <= ram_din;
    end
    ram_dout <= mem[ram_raddr];
  end

  typedef struct {
    int ch;
    int cur;
    int prev;
  } rec_t;

  rec_t exp_q[$];
  rec_t mon_r;
  int   checks = 0;
  int   errors = 0;
  int   m_cur  [CH_NUM];
  int   m_prev [CH_NUM];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL extra_record: got ch %0d with no record expected", out_ch);
      end else begin
        mon_r = exp_q.pop_front();
        check("rec_ch", int'(out_ch), mon_r.ch);
        check($sformatf("rec_cur_ch%0d", mon_r.ch), int'(out_cur), mon_r.cur);
        check($sformatf("rec_prev_ch%0d", mon_r.ch), int'(out_prev), mon_r.prev);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_inc(input int c);
    if (m_cur[c] < RMAX) m_cur[c]++;
  endtask

  task automatic model_clear();
    for (int i = 0; i < CH_NUM; i++) begin
      m_cur[i]  = 0;
      m_prev[i] = 0;
    end
  endtask

  task automatic push_sweep();
    rec_t r;
    for (int i = 0; i < CH_NUM; i++) begin
      r.ch   = i;
      r.cur  = m_cur[i];
      r.prev = m_prev[i];
      exp_q.push_back(r);
      m_prev[i] = m_cur[i];
      m_cur[i]  = 0;
    end
  endtask

  task automatic check_ram_clear(input string name);
    int nz;
    nz = 0;
    for (int i = 0; i < CH_NUM; i++) if (mem[i] != '0) nz++;
    check(name, nz, 0);
  endtask

  // n back-to-back events on one channel, no idle cycles between them
  task automatic ev_burst(input int c, input int n);
    int t;
    t = 0;
    while (!in_ready && t < 100) begin
      tick();
      t++;
    end
    if (!in_ready) check("ev_wait_in_ready", 0, 1);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_ch    = CH_BIT'(c);
      tick();
      model_inc(c);
    end
    in_valid = 1'b0;
  endtask

  task automatic frame(input bit with_ev, input int ev_ch, input int stall, input bit extra_fe);
    int n;
    logic [31:0] snap;
    frame_end = 1'b1;
    if (with_ev) begin
      in_valid = 1'b1;
      in_ch    = CH_BIT'(ev_ch);
    end
    tick();
    frame_end = 1'b0;
    in_valid  = 1'b0;
    if (with_ev) model_inc(ev_ch);
    push_sweep();
    n = 0;
    while (!out_valid && n < 10) begin
      tick();
      n++;
    end
    check("first_valid_latency", n, 2);
    if (stall > 0) begin
      snap = {out_valid, 4'(out_ch), out_cur, out_prev};
      for (int i = 0; i < stall; i++) begin
        tick();
        n++;
        check("stall_record_stable", int'({out_valid, 4'(out_ch), out_cur, out_prev}), int'(snap));
        check("stall_in_ready", int'(in_ready), 0);
      end
      out_ready = 1'b1;
    end
    if (extra_fe) begin
      frame_end = 1'b1;
      tick();
      n++;
      frame_end = 1'b0;
    end
    while (!in_ready && n < 200) begin
      tick();
      n++;
    end
    check("sweep_cycles", n, 2 * CH_NUM + 1 + stall);
    check("records_left", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int hi;
    rst       = 1'b1;
    fill_en   = 1'b1;
    in_valid  = 1'b0;
    in_ch     = '0;
    frame_end = 1'b0;
    out_ready = 1'b1;
    model_clear();
    tick();
    tick();
    fill_en = 1'b0;
    tick();
    check("rst_in_ready", int'(in_ready), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_overrun", int'(overrun), 0);
    check("rst_sweep_busy", int'(sweep_busy), 1);
    check("rst_out_cur", int'(out_cur), 0);
    check("ram_prefilled", int'(mem[3]), 8'hA5);

    rst = 1'b0;
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    check("init_cycles", n, CH_NUM);
    check_ram_clear("init_ram_clear");
    check("acc_sweep_busy", int'(sweep_busy), 0);

    // isolated events with idle gaps
    ev_burst(3, 1);
    tick();
    ev_burst(5, 1);
    tick();
    ev_burst(3, 1);
    tick();
    frame(1'b0, 0, 0, 1'b0);
    check("no_overrun_yet", int'(overrun), 0);

    // same-channel hazard, plus a mixed back-to-back pair
    ev_burst(2, 10);
    ev_burst(6, 1);
    ev_burst(6, 1);
    frame(1'b0, 0, 0, 1'b0);

    // saturation, then rollover of the saturated value into prev
    ev_burst(1, 20);
    frame(1'b0, 0, 0, 1'b0);
    ev_burst(1, 3);
    frame(1'b0, 0, 0, 1'b0);

    // backpressure on ch 0
    ev_burst(0, 2);
    out_ready = 1'b0;
    frame(1'b0, 0, 5, 1'b0);

    // event coincident with frame_end, and a second frame_end mid-sweep
    ev_burst(4, 2);
    frame(1'b1, 4, 0, 1'b1);
    check("overrun_set", int'(overrun), 1);
    hi = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (out_valid) hi++;
    end
    check("no_extra_sweep", hi, 0);
    check("overrun_sticky", int'(overrun), 1);

    // reset in the middle of a sweep
    ev_burst(7, 1);
    frame_end = 1'b1;
    tick();
    frame_end = 1'b0;
    push_sweep();
    repeat (6) tick();
    rst = 1'b1;
    #1;
    check("midrst_out_valid", int'(out_valid), 0);
    check("midrst_in_ready", int'(in_ready), 0);
    check("midrst_overrun", int'(overrun), 0);
    exp_q.delete();
    model_clear();
    tick();
    rst = 1'b0;
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    check("reinit_cycles", n, CH_NUM);
    check_ram_clear("reinit_ram_clear");
    ev_burst(7, 2);
    frame(1'b0, 0, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
